// File: rtl/cnet_arb_pkg.sv
// Shared types and constants for the CPCI->CNET register-access arbiter.
package cnet_arb_pkg;

   // Number of requesters sharing the register channel.
   localparam int NUM_REQ = 2;

   // Width of the read-response wait counter.
   localparam int CNT_W = 8;

   // Read data handed back when CNET never answers a read.
   localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2,
      RD_DONE = 2'd3
   } arb_state_e;

endpackage

// File: rtl/cnet_reg_arbiter_if.sv
// Bundle of requester-side and CNET-side signals around the register arbiter.
// Handshake: a requester raises reqN_valid with its fields and holds all of them
// unchanged until the cycle reqN_ack is seen high; the request is issued to CNET
// (p2n_req) in that same cycle. Read results arrive later as a one-cycle
// reqN_rd_valid pulse and are never back-pressured.
interface cnet_reg_arbiter_if;

   // Requester 0 (PCI target register path)
   logic        req0_valid;
   logic        req0_we;
   logic [31:0] req0_addr;
   logic [31:0] req0_data;
   logic        req0_ack;
   logic        req0_rd_valid;
   logic [31:0] req0_rd_data;
   logic        req0_rd_timeout;

   // Requester 1 (DMA/debug engine)
   logic        req1_valid;
   logic        req1_we;
   logic [31:0] req1_addr;
   logic [31:0] req1_data;
   logic        req1_ack;
   logic        req1_rd_valid;
   logic [31:0] req1_rd_data;
   logic        req1_rd_timeout;

   // CNET pins
   logic [31:0] p2n_addr;
   logic [31:0] p2n_data;
   logic        p2n_we;
   logic        p2n_req;
   logic        p2n_full;
   logic [31:0] n2p_data;
   logic        n2p_rd_rdy;
   logic        spurious_rd;

   // Requesters and the CNET side
   modport master (
      output req0_valid, req0_we, req0_addr, req0_data,
      input  req0_ack, req0_rd_valid, req0_rd_data, req0_rd_timeout,
      output req1_valid, req1_we, req1_addr, req1_data,
      input  req1_ack, req1_rd_valid, req1_rd_data, req1_rd_timeout,
      input  p2n_addr, p2n_data, p2n_we, p2n_req,
      output p2n_full, n2p_data, n2p_rd_rdy,
      input  spurious_rd
   );

   // The arbiter
   modport slave (
      input  req0_valid, req0_we, req0_addr, req0_data,
      output req0_ack, req0_rd_valid, req0_rd_data, req0_rd_timeout,
      input  req1_valid, req1_we, req1_addr, req1_data,
      output req1_ack, req1_rd_valid, req1_rd_data, req1_rd_timeout,
      output p2n_addr, p2n_data, p2n_we, p2n_req,
      input  p2n_full, n2p_data, n2p_rd_rdy,
      output spurious_rd
   );

endinterface

// File: rtl/cnet_rr_arb2.sv
// Two-way round-robin picker. On a tie the port that was not granted last wins;
// last_grant only moves when a grant is actually taken (en high).
module cnet_rr_arb2
   import cnet_arb_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant
);

   logic last_grant_q;
   logic last_grant_d;

   // One-hot pick and next last_grant value
   always_comb begin
      grant        = '0;
      last_grant_d = last_grant_q;
      if (en) begin
         if (valid == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
         end else begin
            grant = valid;
         end
         if (|valid) begin
            last_grant_d = grant[1];
         end
      end
   end

   // last_grant resets to 1 so port 0 takes the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/cnet_reg_arbiter.sv
// Shares the CPCI->CNET register channel between two requesters with
// round-robin arbitration, one outstanding read, and a read timeout.
module cnet_reg_arbiter
   import cnet_arb_pkg::*;
#(
   parameter int          RD_TIMEOUT   = 64,
   parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEF
) (
   input  logic              clk,
   input  logic              reset,
   cnet_reg_arbiter_if.slave bus,
   output arb_state_e        dbg_state
);

   // Last RD_WAIT count value before the read is declared lost
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT - 1);

   arb_state_e       state_q, state_d;
   logic             win_q, win_d;
   logic [31:0]      p2n_addr_q, p2n_addr_d;
   logic [31:0]      p2n_data_q, p2n_data_d;
   logic             p2n_we_q, p2n_we_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic             rd_to_q, rd_to_d;
   logic             spur_q, spur_d;

   logic             arb_en;
   logic [1:0]       grant;

   // Arbitration happens only while idle and CNET can take a request
   assign arb_en = (state_q == IDLE) && !bus.p2n_full;

   cnet_rr_arb2 u_rr (
      .clk   (clk),
      .reset (reset),
      .valid ({bus.req1_valid, bus.req0_valid}),
      .en    (arb_en),
      .grant (grant)
   );

   // Next-state, request capture, response/timeout capture
   always_comb begin
      state_d    = state_q;
      win_d      = win_q;
      p2n_addr_d = p2n_addr_q;
      p2n_data_d = p2n_data_q;
      p2n_we_d   = p2n_we_q;
      cnt_d      = cnt_q;
      rd_data_d  = rd_data_q;
      rd_to_d    = rd_to_q;
      // A response strobe only belongs to us while a read is outstanding
      spur_d     = bus.n2p_rd_rdy && (state_q != RD_WAIT);

      case (state_q)
         IDLE: begin
            if (grant[1]) begin
               win_d      = 1'b1;
               p2n_addr_d = bus.req1_addr;
               p2n_data_d = bus.req1_data;
               p2n_we_d   = bus.req1_we;
               state_d    = ISSUE;
            end else if (grant[0]) begin
               win_d      = 1'b0;
               p2n_addr_d = bus.req0_addr;
               p2n_data_d = bus.req0_data;
               p2n_we_d   = bus.req0_we;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = p2n_we_q ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // The response wins if it lands on the timeout cycle
            if (bus.n2p_rd_rdy) begin
               rd_data_d = bus.n2p_data;
               rd_to_d   = 1'b0;
               state_d   = RD_DONE;
            end else if (cnt_q == TO_LAST) begin
               rd_data_d = TIMEOUT_DATA;
               rd_to_d   = 1'b1;
               state_d   = RD_DONE;
            end
         end
         RD_DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         win_q      <= 1'b0;
         p2n_addr_q <= '0;
         p2n_data_q <= '0;
         p2n_we_q   <= 1'b0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_to_q    <= 1'b0;
         spur_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         win_q      <= win_d;
         p2n_addr_q <= p2n_addr_d;
         p2n_data_q <= p2n_data_d;
         p2n_we_q   <= p2n_we_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_to_q    <= rd_to_d;
         spur_q     <= spur_d;
      end
   end

   // Strobes and routed read results, decoded from registered state
   assign bus.p2n_req         = (state_q == ISSUE);
   assign bus.p2n_addr        = p2n_addr_q;
   assign bus.p2n_data        = p2n_data_q;
   assign bus.p2n_we          = p2n_we_q;
   assign bus.req0_ack        = (state_q == ISSUE) && !win_q;
   assign bus.req1_ack        = (state_q == ISSUE) && win_q;
   assign bus.req0_rd_valid   = (state_q == RD_DONE) && !win_q;
   assign bus.req1_rd_valid   = (state_q == RD_DONE) && win_q;
   assign bus.req0_rd_data    = bus.req0_rd_valid ? rd_data_q : 32'h0;
   assign bus.req1_rd_data    = bus.req1_rd_valid ? rd_data_q : 32'h0;
   assign bus.req0_rd_timeout = bus.req0_rd_valid && rd_to_q;
   assign bus.req1_rd_timeout = bus.req1_rd_valid && rd_to_q;
   assign bus.spurious_rd     = spur_q;
   assign dbg_state           = state_q;

endmodule

// File: tb/tb_cnet_reg_arbiter.sv
// Directed bench for cnet_reg_arbiter: a per-cycle vector table for writes,
// round-robin and backpressure, then hand sequences for reads, timeout and reset.
module tb_cnet_reg_arbiter;
   import cnet_arb_pkg::*;

   localparam logic [31:0] A0 = 32'h0040_0010;
   localparam logic [31:0] D0 = 32'h1234_5678;
   localparam logic [31:0] A1 = 32'h0000_0A00;
   localparam logic [31:0] D1 = 32'hCAFE_0001;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- stimulus variables ----------------
   logic        sel_to = 1'b0;   // 0: default DUT, 1: RD_TIMEOUT=8 DUT
   logic        req0_valid = 1'b0, req0_we = 1'b0;
   logic [31:0] req0_addr = '0, req0_data = '0;
   logic        req1_valid = 1'b0, req1_we = 1'b0;
   logic [31:0] req1_addr = '0, req1_data = '0;
   logic        p2n_full = 1'b0, n2p_rd_rdy = 1'b0;
   logic [31:0] n2p_data = '0;

   cnet_reg_arbiter_if bus_a();
   cnet_reg_arbiter_if bus_b();
   arb_state_e dbg_a, dbg_b;

   assign bus_a.req0_valid = req0_valid & ~sel_to;
   assign bus_b.req0_valid = req0_valid & sel_to;
   assign bus_a.req1_valid = req1_valid & ~sel_to;
   assign bus_b.req1_valid = req1_valid & sel_to;
   assign bus_a.req0_we = req0_we;     assign bus_b.req0_we = req0_we;
   assign bus_a.req0_addr = req0_addr; assign bus_b.req0_addr = req0_addr;
   assign bus_a.req0_data = req0_data; assign bus_b.req0_data = req0_data;
   assign bus_a.req1_we = req1_we;     assign bus_b.req1_we = req1_we;
   assign bus_a.req1_addr = req1_addr; assign bus_b.req1_addr = req1_addr;
   assign bus_a.req1_data = req1_data; assign bus_b.req1_data = req1_data;
   assign bus_a.p2n_full = p2n_full;   assign bus_b.p2n_full = p2n_full;
   assign bus_a.n2p_data = n2p_data;   assign bus_b.n2p_data = n2p_data;
   assign bus_a.n2p_rd_rdy = n2p_rd_rdy;
   assign bus_b.n2p_rd_rdy = n2p_rd_rdy;

   cnet_reg_arbiter dut (
      .clk       (clk),
      .reset     (rst_n),
      .bus       (bus_a),
      .dbg_state (dbg_a)
   );

   cnet_reg_arbiter #(.RD_TIMEOUT(8)) dut_to (
      .clk       (clk),
      .reset     (rst_n),
      .bus       (bus_b),
      .dbg_state (dbg_b)
   );

   // Observed outputs of the selected DUT
   logic        o_req, o_ack0, o_ack1, o_we, o_rv0, o_rv1, o_to0, o_to1, o_spur;
   logic [31:0] o_addr, o_data, o_rd0, o_rd1;
   assign o_req  = sel_to ? bus_b.p2n_req : bus_a.p2n_req;
   assign o_ack0 = sel_to ? bus_b.req0_ack : bus_a.req0_ack;
   assign o_ack1 = sel_to ? bus_b.req1_ack : bus_a.req1_ack;
   assign o_we   = sel_to ? bus_b.p2n_we : bus_a.p2n_we;
   assign o_addr = sel_to ? bus_b.p2n_addr : bus_a.p2n_addr;
   assign o_data = sel_to ? bus_b.p2n_data : bus_a.p2n_data;
   assign o_rv0  = sel_to ? bus_b.req0_rd_valid : bus_a.req0_rd_valid;
   assign o_rv1  = sel_to ? bus_b.req1_rd_valid : bus_a.req1_rd_valid;
   assign o_rd0  = sel_to ? bus_b.req0_rd_data : bus_a.req0_rd_data;
   assign o_rd1  = sel_to ? bus_b.req1_rd_data : bus_a.req1_rd_data;
   assign o_to0  = sel_to ? bus_b.req0_rd_timeout : bus_a.req0_rd_timeout;
   assign o_to1  = sel_to ? bus_b.req1_rd_timeout : bus_a.req1_rd_timeout;
   assign o_spur = sel_to ? bus_b.spurious_rd : bus_a.spurious_rd;

   // ---------------- requester protocol assertion ----------------
   logic prev_v0 = 1'b0, prev_a0 = 1'b0, prev_v1 = 1'b0, prev_a1 = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_v0 && !prev_a0) assert (req0_valid) else $error("req0_valid dropped before ack");
         if (prev_v1 && !prev_a1) assert (req1_valid) else $error("req1_valid dropped before ack");
      end
      prev_v0 = req0_valid && rst_n;
      prev_a0 = o_ack0;
      prev_v1 = req1_valid && rst_n;
      prev_a1 = o_ack1;
   end

   // ---------------- scoreboard ----------------
   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [3:0] in_bits;   // {v0, v1, full, rdy}
      logic [2:0] out_bits;  // {p2n_req, ack0, ack1}
      logic [1:0] hold;      // p2n fields held: 0 reset, 1 port0 write, 2 port1 write
      logic       spur;
   } vec_t;
   vec_t vq[$];

   task automatic add(input logic [3:0] ib, input logic [2:0] ob, input logic [1:0] h, input logic s);
      vec_t v;
      v.in_bits = ib; v.out_bits = ob; v.hold = h; v.spur = s;
      vq.push_back(v);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] ex_addr, ex_data;
   logic        ex_we;
   logic        found, bad;

   initial begin
      // single write from port 0
      add(4'b1000, 3'b000, 2'd0, 1'b0);
      add(4'b1000, 3'b110, 2'd1, 1'b0);
      add(4'b0000, 3'b000, 2'd1, 1'b0);
      // both ports writing continuously: port 0 went last, so 1,0,1,0
      add(4'b1100, 3'b000, 2'd1, 1'b0);
      add(4'b1100, 3'b101, 2'd2, 1'b0);
      add(4'b1100, 3'b000, 2'd2, 1'b0);
      add(4'b1100, 3'b110, 2'd1, 1'b0);
      add(4'b1100, 3'b000, 2'd1, 1'b0);
      add(4'b1100, 3'b101, 2'd2, 1'b0);
      add(4'b1100, 3'b000, 2'd2, 1'b0);
      add(4'b1100, 3'b110, 2'd1, 1'b0);
      add(4'b0100, 3'b000, 2'd1, 1'b0);
      add(4'b0100, 3'b101, 2'd2, 1'b0);
      // full held for 10 cycles with port 0 waiting
      for (int i = 0; i < 10; i++) add(4'b1010, 3'b000, 2'd2, 1'b0);
      add(4'b1000, 3'b000, 2'd2, 1'b0);
      add(4'b1000, 3'b110, 2'd1, 1'b0);
      // stray response while idle
      add(4'b0001, 3'b000, 2'd1, 1'b0);
      add(4'b0000, 3'b000, 2'd1, 1'b1);
      add(4'b0000, 3'b000, 2'd1, 1'b0);

      req0_we = 1'b1; req0_addr = A0; req0_data = D0;
      req1_we = 1'b1; req1_addr = A1; req1_data = D1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      foreach (vq[i]) begin
         next_cycle();
         {req0_valid, req1_valid, p2n_full, n2p_rd_rdy} = vq[i].in_bits;
         @(negedge clk);
         ex_addr = (vq[i].hold == 2'd1) ? A0 : (vq[i].hold == 2'd2) ? A1 : 32'h0;
         ex_data = (vq[i].hold == 2'd1) ? D0 : (vq[i].hold == 2'd2) ? D1 : 32'h0;
         ex_we   = (vq[i].hold != 2'd0);
         check($sformatf("vec%0d", i),
               128'({o_req, o_ack0, o_ack1, o_we, o_addr, o_data, o_rv0, o_rv1, o_spur}),
               128'({vq[i].out_bits, ex_we, ex_addr, ex_data, 1'b0, 1'b0, vq[i].spur}));
      end

      // ---- read routing: port 1 reads, port 0 write waits ----
      next_cycle();
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = A0; req0_data = D0;
      req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 32'h0000_0ABC;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (o_ack1) begin found = 1'b1; break; end
         next_cycle();
      end
      check("rd_ack1", 128'(found), 128'(1));
      bad = o_ack0;
      for (int i = 1; i <= 21; i++) begin
         next_cycle();
         req1_valid = 1'b0;
         n2p_rd_rdy = (i == 21);
         n2p_data   = (i == 21) ? 32'h0000_0ABC : 32'h0;
         @(negedge clk);
         if (o_ack0 || o_req || o_rv0 || o_rv1) bad = 1'b1;
      end
      check("rd_blocked", 128'(bad), 128'(0));
      next_cycle();
      n2p_rd_rdy = 1'b0;
      @(negedge clk);
      check("rd_route", 128'({o_rv0, o_rv1, o_to1, o_to0, o_rd1, o_rd0}),
            128'({1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 32'h0}));
      next_cycle();
      @(negedge clk);
      check("rd_idle", 128'({o_ack0, o_rv1}), 128'(0));
      next_cycle();
      @(negedge clk);
      check("rd_next0", 128'({o_ack0, o_ack1, o_we, o_addr}), 128'({1'b1, 1'b0, 1'b1, A0}));
      next_cycle();
      req0_valid = 1'b0;

      // ---- timeout (RD_TIMEOUT=8) and late response ----
      next_cycle();
      sel_to = 1'b1;
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0000_0100;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (o_ack0) begin found = 1'b1; break; end
         next_cycle();
      end
      check("to_ack0", 128'(found), 128'(1));
      bad = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         next_cycle();
         req0_valid = 1'b0;
         @(negedge clk);
         if (o_rv0 || o_rv1) bad = 1'b1;
      end
      check("to_early", 128'(bad), 128'(0));
      next_cycle();
      @(negedge clk);
      check("to_result", 128'({o_rv0, o_to0, o_rd0, o_rv1}),
            128'({1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0}));
      next_cycle();
      next_cycle();
      next_cycle();
      n2p_rd_rdy = 1'b1; n2p_data = 32'h0000_1111;
      next_cycle();
      n2p_rd_rdy = 1'b0; n2p_data = 32'h0;
      @(negedge clk);
      check("to_late_spur", 128'({o_spur, o_rv0, o_rv1, o_req}), 128'({1'b1, 3'b000}));
      next_cycle();
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = A1; req1_data = D1;
      @(negedge clk);
      check("to_spur_clear", 128'({o_spur, o_ack1}), 128'(0));
      next_cycle();
      @(negedge clk);
      check("to_after_wr", 128'({o_req, o_ack1, o_we, o_addr, o_data}),
            128'({1'b1, 1'b1, 1'b1, A1, D1}));
      next_cycle();
      req1_valid = 1'b0;
      next_cycle();
      sel_to = 1'b0;

      // ---- reset during RD_WAIT ----
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 32'h0000_0100;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (o_ack0) begin found = 1'b1; break; end
         next_cycle();
      end
      check("rst_ack0", 128'(found), 128'(1));
      next_cycle();
      req0_valid = 1'b0;
      next_cycle();
      next_cycle();
      check("rst_in_wait", 128'(dbg_a), 128'(RD_WAIT));
      #2 rst_n = 1'b0;
      #1;
      check("rst_outputs", 128'({o_req, o_ack0, o_ack1, o_we, o_addr, o_data, o_rv0, o_rv1,
                                 o_to0, o_to1, o_spur, (o_rd0 | o_rd1)}), 128'(0));
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      n2p_rd_rdy = 1'b1; n2p_data = 32'h0000_0100;
      next_cycle();
      n2p_rd_rdy = 1'b0;
      @(negedge clk);
      check("rst_late_spur", 128'({o_spur, o_rv0}), 128'({1'b1, 1'b0}));
      next_cycle();
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = A0; req0_data = D0;
      req1_valid = 1'b1; req1_we = 1'b1; req1_addr = A1; req1_data = D1;
      @(negedge clk);
      check("rst_tie_idle", 128'({o_ack0, o_ack1}), 128'(0));
      next_cycle();
      @(negedge clk);
      check("rst_tie_port0", 128'({o_ack0, o_ack1, o_addr}), 128'({2'b10, A0}));
      next_cycle();
      req0_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (o_ack1) begin found = 1'b1; break; end
         next_cycle();
      end
      check("rst_tie_port1", 128'(found), 128'(1));
      next_cycle();
      req1_valid = 1'b0;
      repeat (2) next_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
